mux8_scan_seq: RTL and testbench
================================

# mux8_scan_seq

Sequencer that sits directly upstream of the 8:1 behavioural multiplexer (`mux8`). It latches a byte onto the mux data inputs i0..i7 and steps the select lines {s0,s1,s2} through all eight codes. At each code it samples the mux output back into a capture register, then flags whether the round trip matched, giving a self-checking, scan-style exercise of the mux.

## Interface
Parameters:
- STEP_CYCLES, 1, dwell in clock cycles per select code; legal range 1..255; 0 is illegal.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request a scan; sampled only in IDLE.
- data  input  8  byte to scan; data[k] drives ik.
- dir  input  1  0 = ascending (code 0→7), 1 = descending (7→0); latched with data.
- loop  input  1  1 = restart automatically after each DONE.
- stop  input  1  abort/halt request.
- mux_out  input  1  output of the downstream mux.
- i0..i7  output  1 each  mux data inputs; registered copy of data.
- s0, s1, s2  output  1 each  mux select; code = {s0,s1,s2}, with s0 as MSB.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse marking scan complete.
- cap  output  8  captured bits; cap[k] = mux_out sampled while code = k.
- err  output  1  valid with done; 1 if cap ≠ {i7..i0}.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If start=1 and stop=0: latch data→i0..i7 and dir; drive select to ~first; go to LOAD.
  - first = 3'b000 if dir=0, otherwise 3'b111.
  - If start and stop are both high, stop wins and the block stays in IDLE.
- LOAD:
  - Drive select = first, counter = STEP_CYCLES-1, clear cap to 0; go to RUN.
  - The ~first select value in the preceding cycle guarantees a select transition, which the downstream mux needs because it re-evaluates only on select changes.
  - i0..i7 never change while the select is held in RUN.
- RUN, when the counter is nonzero:
  - Decrement the counter.
- RUN, when the counter reaches 0:
  - cap[code] ← mux_out.
  - If code is the last (7 ascending, 0 descending), go to DONE.
  - Otherwise step code by +1 or −1 (no wrap) and reload the counter.
- RUN, stop=1 at any edge:
  - Go to IDLE at that edge, with no sample taken that edge and no done.
  - cap keeps its partial contents and err is unchanged.
- DONE, lasting one cycle:
  - done=1; err = (cap ≠ {i7,...,i0}), with the final sample included.
  - If loop=1 and stop=0: re-latch data/dir, drive select to ~first, go to LOAD.
  - Otherwise go to IDLE.
- Select holds its last value in IDLE.
- start is ignored while busy=1.
- cap and err hold until the next LOAD (cap) or DONE (err), or until reset.
- Reset clears everything: state IDLE, i0..i7=0, {s0,s1,s2}=000, busy=0, done=0, cap=0, err=0, counter=0.
- Reset mid-scan aborts immediately with the same values and no done.

## Timing
- Start edge E0 → LOAD.
- E1: select = first, state RUN.
- Samples occur at E1 + n·STEP_CYCLES for n = 1..8.
- done is high in the cycle after edge E(1+8·STEP_CYCLES).
  - With STEP_CYCLES=1, done is high between E9 and E10.
- busy rises after E0 and falls after the DONE cycle when loop=0.
- Loop period is 2 + 8·STEP_CYCLES cycles, covering LOAD, RUN and DONE.
- Each select code is held for exactly STEP_CYCLES cycles.
- mux_out is sampled on the last edge of each dwell.
- done and err are registered, not combinational.

## Test plan
- Reset, then data=8'b1101_1001, dir=0, STEP_CYCLES=1, start pulse, mux8 attached:
  - select steps 000→111, one code per cycle.
  - done is high for exactly 1 cycle, 9 edges after the start edge.
  - cap=8'b1101_1001, err=0.
- Same data with dir=1:
  - select 111→000, identical cap, err=0.
  - Select in the LOAD cycle is 000.
- mux_out tied to 0, data=8'hA5:
  - cap=8'h00, err=1 on the done cycle.
  - err holds after done.
- STEP_CYCLES=3, loop=1, data changed to 8'h3C during the first pass:
  - First done at edge 25 with cap=first byte.
  - Second pass uses 8'h3C.
  - Consecutive done pulses are 26 cycles apart.
- stop asserted during the code-4 dwell of an ascending scan:
  - IDLE at that edge, busy=0, no done.
  - cap[3:0] holds valid samples and cap[7:4]=0.
  - A later start completes normally.
- rst pulsed asynchronously mid-RUN (between edges):
  - All outputs go to reset values immediately.
  - A start asserted together with stop in IDLE is ignored.

Source files
------------

// File: rtl/mux8_scan_seq_if.sv
// mux8_scan_seq_if
//   Bundles the control, data and result signals between the scan sequencer
//   and its driver/observer. The downstream mux hookup (i0..i7, s0..s2,
//   mux_out) travels on the same bundle.
//
//   slave  : the sequencer (receives start/data/dir/loop/stop/mux_out,
//            drives i0..i7, s0..s2, busy, done, cap, err)
//   master : the controller/environment side (mirror image)
interface mux8_scan_seq_if;
    logic       start;
    logic [7:0] data;
    logic       dir;
    logic       loop;
    logic       stop;
    logic       mux_out;
    logic       i0, i1, i2, i3, i4, i5, i6, i7;
    logic       s0, s1, s2;
    logic       busy;
    logic       done;
    logic [7:0] cap;
    logic       err;

    modport slave (
        input  start, data, dir, loop, stop, mux_out,
        output i0, i1, i2, i3, i4, i5, i6, i7,
        output s0, s1, s2,
        output busy, done, cap, err
    );

    modport master (
        output start, data, dir, loop, stop, mux_out,
        input  i0, i1, i2, i3, i4, i5, i6, i7,
        input  s0, s1, s2,
        input  busy, done, cap, err
    );
endinterface

// File: rtl/mux8_scan_seq.sv
// mux8_scan_seq
//   Drives an 8:1 mux: latches a byte onto i0..i7, walks the select code
//   {s0,s1,s2} (s0 = MSB) through all eight values, samples mux_out back into
//   cap at the end of each dwell, and flags err on the done pulse when the
//   captured byte differs from the driven byte.
//
//   Parameter STEP_CYCLES : dwell per select code, 1..255.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - slave modport: start/data/dir/loop/stop/mux_out in,
//            i0..i7, s0..s2, busy, done, cap, err out
module mux8_scan_seq #(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mux8_scan_seq_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(STEP_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_data;
    logic       r_dir;
    logic [2:0] r_sel;
    logic [7:0] r_cnt;
    logic [7:0] r_cap;
    logic       r_err;

    state_t     w_state_nxt;
    logic [7:0] w_data_nxt;
    logic       w_dir_nxt;
    logic [2:0] w_sel_nxt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cap_nxt;
    logic       w_err_nxt;

    logic [2:0] w_first_in;   // first code for a scan about to be latched
    logic [2:0] w_first;      // first code for the latched direction
    logic [2:0] w_last;       // final code for the latched direction
    logic [7:0] w_cap_smp;    // cap with the current code's sample merged in

    assign w_first_in = bus.dir ? 3'b111 : 3'b000;
    assign w_first    = r_dir   ? 3'b111 : 3'b000;
    assign w_last     = r_dir   ? 3'b000 : 3'b111;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_cap   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_dir   <= w_dir_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cap   <= w_cap_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_dir_nxt   = r_dir;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_cap_nxt   = r_cap;
        w_err_nxt   = r_err;

        w_cap_smp        = r_cap;
        w_cap_smp[r_sel] = bus.mux_out;

        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_data_nxt  = bus.data;
                    w_dir_nxt   = bus.dir;
                    // Park on the complement so LOAD always changes the select.
                    w_sel_nxt   = ~w_first_in;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_sel_nxt   = w_first;
                w_cnt_nxt   = CNT_RELOAD;
                w_cap_nxt   = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_cap_nxt = w_cap_smp;
                    if (r_sel == w_last) begin
                        // err must already include the final sample on the done cycle.
                        w_err_nxt   = (w_cap_smp != r_data);
                        w_state_nxt = S_DONE;
                    end else begin
                        w_sel_nxt = r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);
                        w_cnt_nxt = CNT_RELOAD;
                    end
                end
            end
            S_DONE: begin
                if (bus.loop && !bus.stop) begin
                    w_data_nxt  = bus.data;
                    w_dir_nxt   = bus.dir;
                    w_sel_nxt   = ~w_first_in;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.i0   = r_data[0];
    assign bus.i1   = r_data[1];
    assign bus.i2   = r_data[2];
    assign bus.i3   = r_data[3];
    assign bus.i4   = r_data[4];
    assign bus.i5   = r_data[5];
    assign bus.i6   = r_data[6];
    assign bus.i7   = r_data[7];
    assign bus.s0   = r_sel[2];
    assign bus.s1   = r_sel[1];
    assign bus.s2   = r_sel[0];
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
    assign bus.cap  = r_cap;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_mux8_scan_seq.sv
// tb_mux8_scan_seq
//   Directed bench for mux8_scan_seq. Two instances: dut_a (one cycle per
//   code) and dut_b (three cycles per code, used for the auto-loop case).
//   A behavioural 8:1 mux closes the loop from i0..i7/s0..s2 to mux_out;
//   dut_a's mux output can be forced low.
module tb_mux8_scan_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mux8_scan_seq_if ifa ();
    mux8_scan_seq_if ifb ();

    mux8_scan_seq #(.STEP_CYCLES(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    mux8_scan_seq #(.STEP_CYCLES(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic       tie0_a;
    logic [7:0] pins_a, pins_b;
    logic [2:0] code_a, code_b;

    assign pins_a = {ifa.i7, ifa.i6, ifa.i5, ifa.i4, ifa.i3, ifa.i2, ifa.i1, ifa.i0};
    assign pins_b = {ifb.i7, ifb.i6, ifb.i5, ifb.i4, ifb.i3, ifb.i2, ifb.i1, ifb.i0};
    assign code_a = {ifa.s0, ifa.s1, ifa.s2};
    assign code_b = {ifb.s0, ifb.s1, ifb.s2};
    assign ifa.mux_out = tie0_a ? 1'b0 : pins_a[code_a];
    assign ifb.mux_out = pins_b[code_b];

    typedef struct packed {
        logic [7:0] cap;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic forced0);
        exp_t e;
        e.cap = forced0 ? 8'h00 : d;
        e.err = (e.cap != d);
        sb_q.push_back(e);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] cap_obs, input logic err_obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $error("FAIL %s: observed result with no expected entry queued", tag);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_cap"}, 32'(cap_obs), 32'(e.cap));
            chk({tag, "_err"}, 32'(err_obs), 32'(e.err));
        end
    endtask

    // Full scan on dut_a, checking select walk, done timing and result.
    task automatic run_scan_a(input logic [7:0] d, input logic dr, input logic forced0);
        @(negedge clk);
        tie0_a    = forced0;
        ifa.data  = d;
        ifa.dir   = dr;
        ifa.start = 1'b1;
        push_exp(d, forced0);
        @(negedge clk);                      // LOAD
        ifa.start = 1'b0;
        ifa.data  = ~d;                      // latched copy must not follow
        chk("load_sel",  32'(code_a), dr ? 32'd0 : 32'd7);
        chk("load_busy", 32'(ifa.busy), 32'd1);
        chk("load_pins", 32'(pins_a), 32'(d));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);                  // after E(1+k)
            chk("run_sel",  32'(code_a), dr ? 32'(7 - k) : 32'(k));
            chk("run_done", 32'(ifa.done), 32'd0);
            chk("run_pins", 32'(pins_a), 32'(d));
        end
        @(negedge clk);                      // after E9
        chk("done_hi", 32'(ifa.done), 32'd1);
        pop_chk("scan_a", ifa.cap, ifa.err);
        @(negedge clk);
        chk("done_lo",   32'(ifa.done), 32'd0);
        chk("idle_busy", 32'(ifa.busy), 32'd0);
    endtask

    initial begin
        int t;

        rst       = 1'b1;
        tie0_a    = 1'b0;
        ifa.start = 1'b0; ifa.data = '0; ifa.dir = 1'b0; ifa.loop = 1'b0; ifa.stop = 1'b0;
        ifb.start = 1'b0; ifb.data = '0; ifb.dir = 1'b0; ifb.loop = 1'b0; ifb.stop = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_busy", 32'(ifa.busy), 32'd0);
        chk("rst_done", 32'(ifa.done), 32'd0);
        chk("rst_sel",  32'(code_a),   32'd0);
        chk("rst_pins", 32'(pins_a),   32'd0);
        chk("rst_cap",  32'(ifa.cap),  32'd0);
        chk("rst_err",  32'(ifa.err),  32'd0);
        rst = 1'b0;

        // Ascending and descending scans of the same byte
        run_scan_a(8'b1101_1001, 1'b0, 1'b0);
        run_scan_a(8'b1101_1001, 1'b1, 1'b0);

        // Mux output stuck low: all-zero capture, err set and held
        run_scan_a(8'hA5, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_hold", 32'(ifa.err), 32'd1);
        chk("cap_hold", 32'(ifa.cap), 32'd0);
        tie0_a = 1'b0;

        // Abort during the code-4 dwell
        @(negedge clk);
        ifa.data  = 8'h5A;
        ifa.dir   = 1'b0;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("stop_at_code", 32'(code_a), 32'd4);
        ifa.stop = 1'b1;
        @(negedge clk);
        ifa.stop = 1'b0;
        chk("stop_busy", 32'(ifa.busy), 32'd0);
        chk("stop_cap",  32'(ifa.cap),  32'h0A);
        chk("stop_err",  32'(ifa.err),  32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("stop_nodone", 32'(ifa.done), 32'd0);
            @(negedge clk);
        end
        run_scan_a(8'h81, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        @(negedge clk);
        ifa.data  = 8'h7E;
        ifa.dir   = 1'b1;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(ifa.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(ifa.busy), 32'd0);
        chk("arst_done", 32'(ifa.done), 32'd0);
        chk("arst_sel",  32'(code_a),   32'd0);
        chk("arst_pins", 32'(pins_a),   32'd0);
        chk("arst_cap",  32'(ifa.cap),  32'd0);
        chk("arst_err",  32'(ifa.err),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // start together with stop is ignored
        ifa.data  = 8'hFF;
        ifa.start = 1'b1;
        ifa.stop  = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.stop  = 1'b0;
        chk("ss_busy", 32'(ifa.busy), 32'd0);
        @(negedge clk);
        chk("ss_busy2", 32'(ifa.busy), 32'd0);
        chk("ss_pins",  32'(pins_a),   32'd0);

        // Auto-loop with 3-cycle dwell; data changes during the first pass
        ifb.data  = 8'hC3;
        ifb.dir   = 1'b0;
        ifb.loop  = 1'b1;
        ifb.start = 1'b1;
        push_exp(8'hC3, 1'b0);
        @(negedge clk);                      // after E0
        ifb.start = 1'b0;
        t = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            t++;
            if (t == 5) begin
                ifb.data = 8'h3C;
                push_exp(8'h3C, 1'b0);
            end
            if (ifb.done) break;
        end
        chk("loop_done1_edge", 32'(t), 32'd25);
        pop_chk("loop1", ifb.cap, ifb.err);
        repeat (2) @(negedge clk);
        t += 2;
        ifb.loop = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            t++;
            if (ifb.done) break;
        end
        chk("loop_done2_edge", 32'(t), 32'd51);
        pop_chk("loop2", ifb.cap, ifb.err);
        @(negedge clk);
        chk("loop_end_busy", 32'(ifb.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
